shift_chain_ctrl: RTL and testbench

Sequencer for a long serial shift chain (default 1024 bits, e.g. a configuration or scan register). It accepts parallel words over a valid/ready write port and serializes them, LSB first, into the chain's serial input under a shift enable. Optionally, it deserializes the bits leaving the chain's serial output into words on a valid/ready read port. The block sits between a bus-side word interface and the chain, and owns the chain's shift enable and clear.

---
 rtl/shift_chain_ctrl.sv | 151 +++++++++++++++
 tb/tb_shift_chain_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_chain_ctrl
// Desc     : Serializes words LSB-first into a long shift chain and owns its
//            shift enable and clear. Define SHIFT_CHAIN_READBACK_EN to also
//            deserialize chain_so into words on the read port.
// Revision : 1.0 - initial release
// ============================================================================
module shift_chain_ctrl #(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              clr_chain,
    output logic              busy,
    output logic              done,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              chain_si,
    input  logic              chain_so,
    output logic              chain_en,
    output logic              chain_clr
);

    localparam int c_NUM_WORDS = CHAIN_LEN / WORD_W;
    localparam int c_WCNT_W    = (c_NUM_WORDS > 1) ? $clog2(c_NUM_WORDS) : 1;
    localparam int c_BCNT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [c_WCNT_W-1:0] c_LAST_WORD = c_WCNT_W'(c_NUM_WORDS - 1);
    localparam logic [c_BCNT_W-1:0] c_LAST_BIT  = c_BCNT_W'(WORD_W - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_CLEAR = 3'd1;
    localparam logic [2:0] c_LOAD  = 3'd2;
    localparam logic [2:0] c_SHIFT = 3'd3;
`ifdef SHIFT_CHAIN_READBACK_EN
    localparam logic [2:0] c_DRAIN = 3'd4;
`endif
    localparam logic [2:0] c_DONE  = 3'd5;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [c_WCNT_W-1:0] r_word_cnt;
    logic [c_BCNT_W-1:0] r_bit_cnt;
    logic [WORD_W-1:0]   r_buf;
    logic                w_last_bit;
    logic                w_last_word;

    assign w_last_bit  = (r_bit_cnt == c_LAST_BIT);
    assign w_last_word = (r_word_cnt == c_LAST_WORD);

`ifdef SHIFT_CHAIN_READBACK_EN
    logic [WORD_W-1:0] r_cap;
    // The word counter has already advanced (and may have wrapped) by the
    // time DRAIN decides, so the last-word decision is kept from SHIFT.
    logic              r_more;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_nxt = clr_chain ? c_CLEAR : c_LOAD;
            c_CLEAR: w_state_nxt = c_LOAD;
            c_LOAD:  if (wr_valid) w_state_nxt = c_SHIFT;
            c_SHIFT: begin
                if (w_last_bit) begin
`ifdef SHIFT_CHAIN_READBACK_EN
                    w_state_nxt = c_DRAIN;
`else
                    w_state_nxt = w_last_word ? c_DONE : c_LOAD;
`endif
                end
            end
`ifdef SHIFT_CHAIN_READBACK_EN
            c_DRAIN: if (rd_ready) w_state_nxt = r_more ? c_LOAD : c_DONE;
`endif
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= c_IDLE;
            r_word_cnt <= '0;
            r_bit_cnt  <= '0;
            r_buf      <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_IDLE: begin
                    r_word_cnt <= '0;
                    r_bit_cnt  <= '0;
                end
                c_LOAD: begin
                    if (wr_valid) begin
                        r_buf     <= wr_data;
                        r_bit_cnt <= '0;
                    end
                end
                c_SHIFT: begin
                    if (w_last_bit) begin
                        r_bit_cnt  <= '0;
                        r_word_cnt <= r_word_cnt + c_WCNT_W'(1);
                    end else begin
                        r_bit_cnt <= r_bit_cnt + c_BCNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SHIFT_CHAIN_READBACK_EN
    // chain_so is the chain's registered last bit, so the value seen during
    // a SHIFT cycle is the bit leaving the chain on that cycle's edge.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_cap  <= '0;
            r_more <= 1'b0;
        end else if (r_state == c_SHIFT) begin
            r_cap[r_bit_cnt] <= chain_so;
            if (w_last_bit) r_more <= !w_last_word;
        end
    end

    assign rd_valid = (r_state == c_DRAIN);
    assign rd_data  = rd_valid ? r_cap : '0;
`else
    logic w_unused_rd;
    assign w_unused_rd = chain_so ^ rd_ready;

    assign rd_valid = 1'b0;
    assign rd_data  = '0;
`endif

    assign busy      = (r_state != c_IDLE);
    assign done      = (r_state == c_DONE);
    assign wr_ready  = (r_state == c_LOAD);
    assign chain_en  = (r_state == c_SHIFT);
    assign chain_clr = (r_state == c_CLEAR);
    assign chain_si  = chain_en & r_buf[r_bit_cnt];

endmodule
`default_nettype wire

// File: tb/tb_shift_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_chain_ctrl
// Desc     : Self-checking bench for shift_chain_ctrl with a 1024-bit chain.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_chain_ctrl;

    localparam int LEN    = 1024;
    localparam int W      = 8;
    localparam int NW     = LEN / W;
    localparam int BUDGET = 8000;
`ifdef SHIFT_CHAIN_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic         clk = 1'b0;
    logic         clr, start, clr_chain, busy, done;
    logic [W-1:0] wr_data, rd_data;
    logic         wr_valid, wr_ready, rd_valid, rd_ready;
    logic         chain_si, chain_so, chain_en, chain_clr;
    logic         chain_init;
    logic [LEN-1:0] chain;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0]   words  [NW];
    logic [W-1:0]   prev_w [NW];
    bit             model_ok;
    logic [LEN-1:0] last_stream;
    logic [LEN-1:0] base_stream;

    always #5 clk = ~clk;

    // The external chain: shifts chain_si in at bit 0, exits at bit LEN-1.
    always @(posedge clk) begin
        if (chain_init || chain_clr) chain <= '0;
        else if (chain_en)           chain <= {chain[LEN-2:0], chain_si};
    end
    assign chain_so = chain[LEN-1];

    shift_chain_ctrl #(.CHAIN_LEN(LEN), .WORD_W(W)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .clr_chain (clr_chain),
        .busy      (busy),
        .done      (done),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .chain_si  (chain_si),
        .chain_so  (chain_so),
        .chain_en  (chain_en),
        .chain_clr (chain_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({busy, done, wr_ready, rd_valid, rd_data, chain_si, chain_en, chain_clr});
    endfunction

    typedef struct {
        logic         start;
        logic         clr_chain;
        logic         wr_valid;
        logic [W-1:0] wr_data;
        logic         clr;
        logic [6:0]   exp;   // {busy, wr_ready, chain_clr, chain_en, chain_si, done, rd_valid}
    } vec_t;

    function automatic vec_t mk(input logic s, input logic cc, input logic wv,
                                input logic [W-1:0] d, input logic c, input logic [6:0] e);
        vec_t v;
        v.start = s; v.clr_chain = cc; v.wr_valid = wv; v.wr_data = d; v.clr = c; v.exp = e;
        return v;
    endfunction

    // One full pass driven from words[]; expectations come from words[] and
    // prev_w[] (what the chain held before this pass).
    task automatic run_pass(input bit cc, input int gap_after, input int gap_len,
                            input int stall_word, input int stall_len,
                            input int abort_at, input bit rnd);
        int t, sh, widx, ridx, gap, stall, done_t, n_done, n_clr, clr_t, rdy_t;
        int bit_err, gap_err, rb_err, hold_err, so_err, cc_err, extra;
        bit aborting, hold_chk, finished, know_prev;
        logic [W-1:0] hold_val;
        logic [W-1:0] rb [NW];
        logic [W-1:0] pexp [NW];
        sh = 0; widx = 0; ridx = 0; gap = 0; stall = 0; done_t = -1; n_done = 0;
        n_clr = 0; clr_t = -1; rdy_t = -1; bit_err = 0; gap_err = 0; rb_err = 0;
        hold_err = 0; so_err = 0; cc_err = 0; aborting = 0; hold_chk = 0;
        finished = 0; hold_val = '0;
        know_prev = cc || model_ok;
        for (int k = 0; k < NW; k++) begin
            pexp[k] = cc ? '0 : prev_w[k];
            rb[k]   = '0;
        end
        last_stream = '0;

        @(negedge clk);
        start = 1'b1; clr_chain = cc; wr_valid = 1'b0; rd_ready = 1'b0;
        for (t = 1; t <= BUDGET; t++) begin
            @(negedge clk);
            start = 1'b0;
            if (aborting) begin
                check("abort_outputs", outs(), 32'd0);
                clr = 1'b0; wr_valid = 1'b0; model_ok = 1'b0;
                return;
            end
            if (done_t >= 0) begin
                check("done_then_idle", 32'({busy, done}), 32'd0);
                finished = 1;
                break;
            end
            if (chain_clr) begin
                n_clr++;
                if (clr_t < 0) clr_t = t;
            end
            if (wr_ready && rdy_t < 0) rdy_t = t;
            if (done) begin
                n_done++; done_t = t; start = 1'b1;
            end else if (busy && $urandom_range(0, 15) == 0) begin
                start = 1'b1;
            end

            if (chain_en) begin
                if (sh < LEN) begin
                    if (chain_si !== words[sh / W][sh % W]) bit_err++;
                    if (know_prev && chain_so !== pexp[sh / W][sh % W]) so_err++;
                    last_stream[sh] = chain_si;
                end else begin
                    bit_err++;
                end
                if (sh == abort_at) begin
                    clr = 1'b1; aborting = 1;
                end
                sh++;
            end

            if (wr_ready) begin
                if (widx == gap_after && gap < gap_len) begin
                    wr_valid = 1'b0; gap++;
                    if (chain_en) gap_err++;
                end else if (rnd && $urandom_range(0, 3) == 0) begin
                    wr_valid = 1'b0;
                end else begin
                    wr_valid = 1'b1;
                    wr_data  = (widx < NW) ? words[widx] : '0;
                    widx++;
                end
            end else begin
                wr_valid = 1'($urandom_range(0, 1));
                wr_data  = W'($urandom);
            end

`ifdef SHIFT_CHAIN_READBACK_EN
            if (rd_valid) begin
                if (hold_chk && rd_data !== hold_val) hold_err++;
                if (ridx == stall_word && stall < stall_len) begin
                    rd_ready = 1'b0; stall++;
                    if (chain_en) gap_err++;
                end else begin
                    rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (rd_ready) begin
                    if (ridx < NW) rb[ridx] = rd_data;
                    ridx++; hold_chk = 0;
                end else begin
                    hold_chk = 1; hold_val = rd_data;
                end
            end else begin
                if (hold_chk) hold_err++;
                hold_chk = 0;
                rd_ready = 1'($urandom_range(0, 1));
            end
`else
            if (rd_valid !== 1'b0 || rd_data !== '0) rb_err++;
            rd_ready = 1'($urandom_range(0, 1));
`endif
        end

        if (!finished) begin
            $display("FAIL pass_timeout: got no done within %0d cycles, expected done", BUDGET);
            n_tests++; n_fail++;
            clr = 1'b1; @(negedge clk); clr = 1'b0; model_ok = 1'b0;
            return;
        end

        check("done_count", 32'(n_done), 32'd1);
        check("chain_clr_pulses", 32'(n_clr), 32'(cc));
        if (cc) check("chain_clr_cycle", 32'(clr_t), 32'd1);
        check("wr_ready_first", 32'(rdy_t), 32'(1 + cc));
        check("shift_count", 32'(sh), 32'(LEN));
        check("bitstream_errs", 32'(bit_err), 32'd0);
        check("so_errs", 32'(so_err), 32'd0);
        check("en_in_gap", 32'(gap_err), 32'd0);
        for (int i = 0; i < LEN; i++)
            if (chain[LEN-1-i] !== words[i / W][i % W]) cc_err++;
        check("chain_contents", 32'(cc_err), 32'd0);
`ifdef SHIFT_CHAIN_READBACK_EN
        check("read_count", 32'(ridx), 32'(NW));
        if (know_prev) begin
            for (int k = 0; k < NW; k++)
                if (rb[k] !== pexp[k]) rb_err++;
            check("readback_errs", 32'(rb_err), 32'd0);
        end
        check("rd_hold_errs", 32'(hold_err), 32'd0);
`else
        check("rd_port_idle", 32'(rb_err), 32'd0);
`endif
        if (!rnd)
            check("pass_length", 32'(done_t),
                  32'(1 + cc + NW * (W + 1 + RB) + gap_len + stall_len * RB));

        extra = 0;
        wr_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (busy || chain_en) extra++;
        end
        check("no_extra_pass", 32'(extra), 32'd0);
        for (int k = 0; k < NW; k++) prev_w[k] = words[k];
        model_ok = 1'b1;
    endtask

    vec_t vt [16];

    initial begin
        clr = 1'b1; chain_init = 1'b1; start = 1'b0; clr_chain = 1'b0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        for (int k = 0; k < NW; k++) prev_w[k] = '0;
        model_ok = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 32'd0);
        clr = 1'b0; chain_init = 1'b0;

        // Cycle-exact table: CLEAR start, ignored data outside LOAD, a one-cycle
        // write stall, 0x01 bit order, abort mid-shift and a fresh start.
        vt[0]  = mk(1, 1, 0, 8'h00, 0, 7'b0000000);
        vt[1]  = mk(0, 0, 1, 8'hFF, 0, 7'b1010000);
        vt[2]  = mk(0, 0, 0, 8'h00, 0, 7'b1100000);
        vt[3]  = mk(0, 0, 1, 8'h01, 0, 7'b1100000);
        vt[4]  = mk(1, 0, 1, 8'hFF, 0, 7'b1001100);
        for (int i = 5; i <= 10; i++) vt[i] = mk(0, 0, 0, 8'h00, 0, 7'b1001000);
        vt[11] = mk(0, 0, 0, 8'h00, 1, 7'b1001000);
        vt[12] = mk(1, 0, 0, 8'h00, 0, 7'b0000000);
        vt[13] = mk(0, 0, 1, 8'h3C, 0, 7'b1100000);
        vt[14] = mk(0, 0, 0, 8'h00, 1, 7'b1001000);
        vt[15] = mk(0, 0, 0, 8'h00, 0, 7'b0000000);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check($sformatf("vec[%0d]", i),
                  32'({busy, wr_ready, chain_clr, chain_en, chain_si, done, rd_valid}),
                  32'(vt[i].exp));
            start = vt[i].start; clr_chain = vt[i].clr_chain; wr_valid = vt[i].wr_valid;
            wr_data = vt[i].wr_data; clr = vt[i].clr;
        end
        wr_valid = 1'b0; clr = 1'b0;
        model_ok = 1'b0;

        // Counting pattern into a cleared chain, then read it back.
        for (int k = 0; k < NW; k++) words[k] = W'(k);
        run_pass(1, -1, 0, -1, 0, -1, 0);
        run_pass(0, -1, 0, -1, 0, -1, 0);
        base_stream = last_stream;

        // Same words with a 5-cycle write gap after word 10.
        run_pass(0, 11, 5, -1, 0, -1, 0);
        check("gap_vs_nogap", 32'($countones(last_stream ^ base_stream)), 32'd0);

        // Fill with 0xA5, then stall the read of word 0 for 7 cycles.
        for (int k = 0; k < NW; k++) words[k] = 8'hA5;
        run_pass(0, -1, 0, -1, 0, -1, 0);
        for (int k = 0; k < NW; k++) words[k] = W'($urandom);
        run_pass(0, -1, 0, 0, 7, -1, 0);

        // Abort at word 3 bit 4, then a fresh pass checking bit order.
        run_pass(1, -1, 0, -1, 0, 3 * W + 4, 0);
        for (int k = 0; k < NW; k++) words[k] = '0;
        words[0] = 8'h01;
        run_pass(1, -1, 0, -1, 0, -1, 0);
        check("si_ones", 32'($countones(last_stream)), 32'd1);
        check("si_first", 32'(last_stream[0]), 32'd1);
        check("so_after_full", 32'(chain_so), 32'd1);

        // Random words with random backpressure on both ports.
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < NW; k++) words[k] = W'($urandom);
            run_pass(1'($urandom_range(0, 1)), -1, 0, -1, 0, -1, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
